pipe_hazard_ctrl: RTL and testbench

- Central pipeline-control sequencer for the 5-stage Y86-64 core; drives stall/bubble of the F, D, E, M and W pipeline registers.
- Resolves load/use, mispredicted-branch and ret hazards, and freezes the pipe while data memory is not ready.
- Enforces a memory-wait timeout and latches a halted state on any non-AOK write-back status.
- Keeps saturating stall/bubble performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-control sequencer for the 5-stage Y86-64 core: per-stage stall/bubble
// generation, memory-wait freeze with timeout, halt latch and saturating counters.

module pipe_hazard_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             m_mem_req_i,
    input  logic             dmem_ready_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_bubble_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_nxt;
    logic            err_nxt;

    logic lu, ret, mp, mw, exc_m, exc_w;

    assign lu    = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE)
                   && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign ret   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    assign mp    = (E_icode_i == IJXX) && !e_Cnd_i;
    assign mw    = m_mem_req_i && !dmem_ready_i;
    assign exc_m = (m_stat_i != SAOK);
    assign exc_w = (W_stat_i != SAOK);

    // rst_i is folded in so the stage controls drop the moment reset asserts.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        W_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_bubble_o = 1'b0;
        if (rst_i) begin
            F_stall_o = 1'b0;
        end else if (state == HALT) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
        end else if (mw) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_stall_o  = 1'b1;
            W_bubble_o = 1'b1;
        end else begin
            F_stall_o  = lu | ret;
            D_stall_o  = lu;
            D_bubble_o = mp | (!lu & ret);
            E_bubble_o = mp | lu;
            M_bubble_o = exc_m | exc_w;
            W_stall_o  = exc_w;
        end
    end

    // A write-back exception wins over every other transition.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_nxt   = mem_err_o;
        case (state)
            RUN: begin
                if (exc_w) begin
                    state_nxt = HALT;
                end else if (mw) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (exc_w) begin
                    state_nxt = HALT;
                end else if (!mw) begin
                    state_nxt = RUN;
                end else if (wait_cnt == TO_MAX) begin
                    state_nxt = HALT;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + TO_W'(1);
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mem_err_o <= err_nxt;
        end
    end

    assign state_o  = state;
    assign halted_o = (state == HALT);

    // [0] stall counter, [1] bubble counter
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_q;

    assign cnt_inc[0] = F_stall_o && (state != HALT);
    assign cnt_inc[1] = D_bubble_o || E_bubble_o;

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        pipe_hazard_sat_cnt #(.W(CNT_W)) u_cnt (
            .clk (clk_i),
            .rst (rst_i),
            .inc (cnt_inc[g]),
            .cnt (cnt_q[g])
        );
    end

    assign stall_cnt_o  = cnt_q[0];
    assign bubble_cnt_o = cnt_q[1];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational hazard table in RUN plus
// hand-written sequences for memory wait, timeout, exception halt and saturation.

module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic e_Cnd, m_mem_req, dmem_ready;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble;
    logic [1:0] state;
    logic halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
    logic [8:0] outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
        .m_mem_req_i(m_mem_req), .dmem_ready_i(dmem_ready),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .E_stall_o(E_stall),
        .M_stall_o(M_stall), .W_stall_o(W_stall),
        .D_bubble_o(D_bubble), .E_bubble_o(E_bubble), .M_bubble_o(M_bubble),
        .W_bubble_o(W_bubble), .state_o(state), .halted_o(halted),
        .mem_err_o(mem_err), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
    );

    // {F,D,E,M,W stall, D,E,M,W bubble}
    assign outs = {F_stall, D_stall, E_stall, M_stall, W_stall,
                   D_bubble, E_bubble, M_bubble, W_bubble};

    typedef struct {
        string      name;
        logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [2:0] mstat, wstat;
        logic       req, rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
        M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
        m_mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_lu();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        // reset state
        #2;
        chk("rst_outs", 32'(outs), 32'h0);
        set_lu();
        #1;
        chk("rst_outs_lu", 32'(outs), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        chk("rst_scnt", 32'(stall_cnt), 32'h0);
        chk("rst_bcnt", 32'(bubble_cnt), 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        // name d_icode srcA srcB e_icode e_dstM cnd m_icode mstat wstat req rdy exp
        vecs.push_back('{"idle",      4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b000000000});
        vecs.push_back('{"lu_srcA",   4'h1,4'h3,4'hF,4'h5,4'h3,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b110000100});
        vecs.push_back('{"lu_srcB",   4'h1,4'hF,4'h4,4'hB,4'h4,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b110000100});
        vecs.push_back('{"lu_rnone",  4'h1,4'hF,4'hF,4'h5,4'hF,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b000000000});
        vecs.push_back('{"nolu_op",   4'h1,4'h3,4'hF,4'h6,4'h3,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b000000000});
        vecs.push_back('{"ret_D",     4'h9,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b100001000});
        vecs.push_back('{"ret_M",     4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h9,3'd1,3'd1,1'b0,1'b1,9'b100001000});
        vecs.push_back('{"mispred",   4'h1,4'hF,4'hF,4'h7,4'hF,1'b0,4'h1,3'd1,3'd1,1'b0,1'b1,9'b000001100});
        vecs.push_back('{"jxx_taken", 4'h1,4'hF,4'hF,4'h7,4'hF,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b000000000});
        vecs.push_back('{"ret_mp",    4'h9,4'hF,4'hF,4'h7,4'hF,1'b0,4'h1,3'd1,3'd1,1'b0,1'b1,9'b100001100});
        vecs.push_back('{"lu_ret",    4'h9,4'h3,4'hF,4'h5,4'h3,1'b1,4'h1,3'd1,3'd1,1'b0,1'b1,9'b110000100});
        vecs.push_back('{"m_exc",     4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd3,3'd1,1'b0,1'b1,9'b000000010});
        vecs.push_back('{"w_exc",     4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd1,3'd3,1'b0,1'b1,9'b000010010});
        vecs.push_back('{"mw",        4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd1,3'd1,1'b1,1'b0,9'b111100001});
        vecs.push_back('{"mw_lu",     4'h1,4'h3,4'hF,4'h5,4'h3,1'b1,4'h1,3'd1,3'd1,1'b1,1'b0,9'b111100001});
        vecs.push_back('{"req_ready", 4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd1,3'd1,1'b1,1'b1,9'b000000000});
        vecs.push_back('{"mw_wexc",   4'h1,4'hF,4'hF,4'h1,4'hF,1'b1,4'h1,3'd1,3'd3,1'b1,1'b0,9'b111100001});

        // each vector is applied and removed between edges, with a reset to keep state at RUN
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            D_icode = vecs[i].d_icode; d_srcA = vecs[i].srca; d_srcB = vecs[i].srcb;
            E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm; e_Cnd = vecs[i].cnd;
            M_icode = vecs[i].m_icode; m_stat = vecs[i].mstat; W_stat = vecs[i].wstat;
            m_mem_req = vecs[i].req; dmem_ready = vecs[i].rdy;
            #1;
            chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
            idle();
            do_reset();
        end

        // load/use counted once
        @(negedge clk);
        set_lu();
        #1;
        chk("lu_scnt0", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("lu_scnt1", 32'(stall_cnt), 32'h1);
        chk("lu_bcnt1", 32'(bubble_cnt), 32'h1);
        chk("lu_gone", 32'(outs), 32'h0);
        do_reset();

        // memory wait of 3 cycles, then release
        @(negedge clk);
        m_mem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mw_state%0d", k), 32'(state), (k == 0) ? 32'h0 : 32'h1);
            chk($sformatf("mw_outs%0d", k), 32'(outs), 32'b111100001);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        chk("mw_rel_state", 32'(state), 32'h1);
        chk("mw_rel_outs", 32'(outs), 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("mw_back_run", 32'(state), 32'h0);
        chk("mw_scnt", 32'(stall_cnt), 32'h3);
        chk("mw_noerr", 32'(mem_err), 32'h0);
        do_reset();

        // timeout: 6 frozen cycles then HALT with error
        @(negedge clk);
        m_mem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("to_state%0d", k), 32'(state), (k == 0) ? 32'h0 : 32'h1);
            chk($sformatf("to_err%0d", k), 32'(mem_err), 32'h0);
            @(negedge clk);
        end
        #1;
        chk("to_halt", 32'(state), 32'h2);
        chk("to_halted", 32'(halted), 32'h1);
        chk("to_err", 32'(mem_err), 32'h1);
        chk("to_outs", 32'(outs), 32'b111110000);
        dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("to_stay_halt", 32'(state), 32'h2);
        chk("to_scnt", 32'(stall_cnt), 32'h6);
        // async reset between edges
        rst = 1'b1;
        #1;
        chk("to_arst_state", 32'(state), 32'h0);
        chk("to_arst_err", 32'(mem_err), 32'h0);
        chk("to_arst_outs", 32'(outs), 32'h0);
        chk("to_arst_scnt", 32'(stall_cnt), 32'h0);
        rst = 1'b0;
        idle();

        // write-back exception
        @(negedge clk);
        W_stat = 3'd3;
        #1;
        chk("exc_outs", 32'(outs), 32'b000010010);
        chk("exc_not_halted", 32'(halted), 32'h0);
        @(negedge clk);
        W_stat = 3'd1;
        set_lu();
        #1;
        chk("exc_halted", 32'(halted), 32'h1);
        chk("exc_state", 32'(state), 32'h2);
        chk("exc_halt_outs", 32'(outs), 32'b111110000);
        @(negedge clk);
        #1;
        chk("exc_no_cnt_halt", 32'(stall_cnt), 32'h0);
        rst = 1'b1;
        #1;
        chk("exc_arst_state", 32'(state), 32'h0);
        chk("exc_arst_outs", 32'(outs), 32'h0);
        chk("exc_arst_bcnt", 32'(bubble_cnt), 32'h0);
        rst = 1'b0;

        // saturation: lu still applied for 20 cycles
        repeat (20) @(negedge clk);
        #1;
        chk("sat_scnt", 32'(stall_cnt), 32'hF);
        chk("sat_bcnt", 32'(bubble_cnt), 32'hF);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
